// File: rtl/clkctrl_pkg.sv
// Package: clkctrl_pkg
// Shared run-control state encoding and divider constants for clk_run_ctrl.
package clkctrl_pkg;

  typedef enum logic [1:0] {
    HALT      = 2'd0,
    RUN       = 2'd1,
    STEP      = 2'd2,
    STEP_WAIT = 2'd3
  } run_state_e;

  // A programmed period of zero runs the core at full rate instead of stalling it.
  localparam bit DIV_ZERO_AS_ONE = 1'b1;

endpackage

// File: rtl/ce_divider.sv
// Module: ce_divider
// Period counter for RUN mode: ticks once every div_lat enabled cycles, reloading the period on each tick.
module ce_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_eff,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_lat;

  assign tick = enable && (div_cnt == div_lat - ONE);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the values from before the edge.
    if (!rst_n) begin
      div_cnt <= '0;
      div_lat <= '0;
    end else if (clear || tick) begin
      // A new period length is only picked up at a boundary, never mid-period.
      div_cnt <= '0;
      div_lat <= div_eff;
    end else if (enable) begin
      div_cnt <= div_cnt + ONE;
    end
  end

endmodule

// File: rtl/clk_run_ctrl.sv
// Module: clk_run_ctrl
// HALT/RUN/single-STEP clock-enable generator for the CPU core; optional breakpoint under CLKCTRL_BKPT_EN.
module clk_run_ctrl
  import clkctrl_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             halt_i,
  input  logic             step_req_i,
  input  logic [DIV_W-1:0] div_i,
`ifdef CLKCTRL_BKPT_EN
  input  logic [7:0]       pc_i,
  input  logic [7:0]       bkpt_addr_i,
  input  logic             bkpt_en_i,
  output logic             bkpt_hit_o,
`endif
  output logic             ce_o,
  output logic             running_o,
  output logic             step_ack_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  run_state_e       state;
  logic             run_q;
  logic             run_edge;
  logic             enter_run;
  logic             tick;
  logic             bkpt_stop;
  logic [DIV_W-1:0] div_eff;

  assign run_edge  = run_i && !run_q;
  assign enter_run = (state == HALT) && run_edge && !halt_i;
  assign div_eff   = (DIV_ZERO_AS_ONE && div_i == '0) ? DIV_W'(1) : div_i;

`ifdef CLKCTRL_BKPT_EN
  // Only instructions retired by a RUN-mode enable are compared; single steps never trip it.
  assign bkpt_stop = (state == RUN) && ce_o && bkpt_en_i && (pc_i == bkpt_addr_i);

  always_ff @(posedge clk) begin
    if (!rst_n)        bkpt_hit_o <= 1'b0;
    else if (bkpt_stop) bkpt_hit_o <= 1'b1;
    else if (run_edge)  bkpt_hit_o <= 1'b0;
  end
`else
  assign bkpt_stop = 1'b0;
`endif

  ce_divider #(.DIV_W(DIV_W)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (enter_run),
    .enable  (state == RUN),
    .div_eff (div_eff),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HALT;
      run_q      <= 1'b0;
      ce_o       <= 1'b0;
      running_o  <= 1'b0;
      step_ack_o <= 1'b0;
    end else begin
      run_q <= run_i;
      ce_o  <= 1'b0;
      unique case (state)
        HALT: begin
          if (enter_run) begin
            state     <= RUN;
            running_o <= 1'b1;
          end else if (step_req_i && !halt_i) begin
            state      <= STEP;
            ce_o       <= 1'b1;
            step_ack_o <= 1'b1;
          end
        end
        RUN: begin
          // A stop request swallows a coinciding period boundary.
          if (halt_i || bkpt_stop) begin
            state     <= HALT;
            running_o <= 1'b0;
          end else if (tick) begin
            ce_o <= 1'b1;
          end
        end
        STEP:      state <= STEP_WAIT;
        STEP_WAIT: begin
          if (!step_req_i) begin
            state      <= HALT;
            step_ack_o <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    cycle_cnt_o <= '0;
    else if (ce_o) cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
  end

endmodule

// File: tb/tb_clk_run_ctrl.sv
// Testbench: tb_clk_run_ctrl
// Directed scenarios plus randomized traffic, every cycle compared against a period-counting reference model.
module tb_clk_run_ctrl;

  localparam int DIV_W = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run_i;
  logic             halt_i;
  logic             step_req_i;
  logic [DIV_W-1:0] div_i;
  logic             ce_o;
  logic             running_o;
  logic             step_ack_o;
  logic [CNT_W-1:0] cycle_cnt_o;
`ifdef CLKCTRL_BKPT_EN
  logic [7:0]       pc_i;
  logic [7:0]       bkpt_addr_i;
  logic             bkpt_en_i;
  logic             bkpt_hit_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: mode flags and elapsed cycles within the current period.
  bit m_running, m_ce, m_run_prev, m_hit;
  int m_step;     // 0 idle, 1 pulse cycle, 2 waiting for request to drop
  int m_elapsed, m_period, m_cnt;

  clk_run_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (run_i),
    .halt_i      (halt_i),
    .step_req_i  (step_req_i),
    .div_i       (div_i),
`ifdef CLKCTRL_BKPT_EN
    .pc_i        (pc_i),
    .bkpt_addr_i (bkpt_addr_i),
    .bkpt_en_i   (bkpt_en_i),
    .bkpt_hit_o  (bkpt_hit_o),
`endif
    .ce_o        (ce_o),
    .running_o   (running_o),
    .step_ack_o  (step_ack_o),
    .cycle_cnt_o (cycle_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic int eff(logic [DIV_W-1:0] d);
    return (d == 0) ? 1 : int'(d);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit edge_run, prev_ce, bk;
    if (!rst_n) begin
      m_running = 0; m_ce = 0; m_run_prev = 0; m_hit = 0;
      m_step = 0; m_elapsed = 0; m_period = 1; m_cnt = 0;
      return;
    end
    prev_ce    = m_ce;
    m_cnt      = (m_cnt + (prev_ce ? 1 : 0)) % (1 << CNT_W);
    edge_run   = run_i && !m_run_prev;
    m_run_prev = run_i;
    m_ce       = 0;
    bk         = 0;
`ifdef CLKCTRL_BKPT_EN
    bk = m_running && prev_ce && bkpt_en_i && (pc_i == bkpt_addr_i);
    if (bk) m_hit = 1;
    else if (edge_run) m_hit = 0;
`endif
    if (m_running) begin
      if (halt_i || bk) m_running = 0;
      else begin
        m_elapsed++;
        if (m_elapsed >= m_period) begin
          m_ce = 1; m_elapsed = 0; m_period = eff(div_i);
        end
      end
    end else if (m_step == 1) m_step = 2;
    else if (m_step == 2) begin
      if (!step_req_i) m_step = 0;
    end else if (edge_run && !halt_i) begin
      m_running = 1; m_elapsed = 0; m_period = eff(div_i);
    end else if (step_req_i && !halt_i) begin
      m_ce = 1; m_step = 1;
    end
  endtask

  task automatic cyc(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("ce_o",        32'(ce_o),        32'(m_ce));
      check("running_o",   32'(running_o),   32'(m_running));
      check("step_ack_o",  32'(step_ack_o),  32'(m_step != 0));
      check("cycle_cnt_o", 32'(cycle_cnt_o), m_cnt);
`ifdef CLKCTRL_BKPT_EN
      check("bkpt_hit_o",  32'(bkpt_hit_o),  32'(m_hit));
`endif
    end
  endtask

  task automatic pulse_run();
    run_i = 1'b1; cyc(1); run_i = 1'b0;
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0; cyc(n); rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; run_i = 1'b0; halt_i = 1'b0; step_req_i = 1'b0; div_i = 8'd4;
`ifdef CLKCTRL_BKPT_EN
    pc_i = 8'h00; bkpt_addr_i = 8'h10; bkpt_en_i = 1'b0;
`endif

    // Reset, then free-run at period 4
    do_reset(3);
    check("rst_cnt", 32'(cycle_cnt_o), 32'd0);
    pulse_run();
    cyc(3);
    check("div4_no_early_ce", 32'(ce_o), 32'd0);
    cyc(1);
    check("div4_first_ce", 32'(ce_o), 32'd1);
    cyc(9);

    // Period 1 from fresh reset, 17 pulses then halt on a boundary
    do_reset(1);
    div_i = 8'd1;
    pulse_run();
    cyc(17);
    halt_i = 1'b1;
    cyc(1);
    check("halt_boundary_ce", 32'(ce_o), 32'd0);
    check("halt_running", 32'(running_o), 32'd0);
    check("wrap_cnt", 32'(cycle_cnt_o), 32'd1);
    cyc(3);
    check("cnt_frozen", 32'(cycle_cnt_o), 32'd1);
    halt_i = 1'b0;

    // Single step with request held for 10 cycles
    step_req_i = 1'b1;
    cyc(10);
    check("step_ack_held", 32'(step_ack_o), 32'd1);
    step_req_i = 1'b0;
    cyc(3);
    check("step_back_halt", 32'(step_ack_o), 32'd0);

    // Period 0 runs every cycle; run edge with halt from HALT stays halted
    div_i = 8'd0;
    pulse_run();
    cyc(6);
    halt_i = 1'b1; cyc(1);
    run_i = 1'b1; cyc(1); run_i = 1'b0;
    cyc(2);
    check("run_halt_stays", 32'(running_o), 32'd0);
    halt_i = 1'b0;

    // Period change mid-run, then reset while running
    div_i = 8'd3;
    pulse_run();
    cyc(4);
    div_i = 8'd5;
    cyc(14);
    rst_n = 1'b0; cyc(1);
    check("rst_mid_run_running", 32'(running_o), 32'd0);
    check("rst_mid_run_ce", 32'(ce_o), 32'd0);
    rst_n = 1'b1;
    cyc(2);

`ifdef CLKCTRL_BKPT_EN
    // Breakpoint at 8'h10 reached on an enable cycle
    div_i = 8'd2; bkpt_en_i = 1'b1; pc_i = 8'h10;
    pulse_run();
    cyc(4);
    check("bkpt_hit", 32'(bkpt_hit_o), 32'd1);
    check("bkpt_halted", 32'(running_o), 32'd0);
    pc_i = 8'h00;
    cyc(3);
    pulse_run();
    check("bkpt_cleared", 32'(bkpt_hit_o), 32'd0);
    halt_i = 1'b1; cyc(1); halt_i = 1'b0;
    bkpt_en_i = 1'b0;
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      run_i  = ($urandom_range(0, 15) == 0);
      halt_i = ($urandom_range(0, 19) == 0);
      if (step_req_i) step_req_i = ($urandom_range(0, 3) != 0);
      else            step_req_i = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) div_i = 8'($urandom_range(0, 5));
`ifdef CLKCTRL_BKPT_EN
      pc_i = 8'($urandom_range(0, 31));
      bkpt_en_i = ($urandom_range(0, 3) == 0);
`endif
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
